// File: rtl/cpu_defs.sv
// Shared definitions for the instruction-fetch path: state encoding, reset PC
// and instruction width.
package cpu_defs;

  localparam int          INST_W       = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_out_stage.sv
// One-entry valid/ready output register between fetch and decode.
// Flush beats load; an accepted entry with no refill drops valid.
module fetch_out_stage
  import cpu_defs::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              flush,
  input  logic [INST_W-1:0] in_inst,
  input  logic [31:0]       in_pc,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [INST_W-1:0] out_inst,
  output logic [31:0]       out_pc
);

  logic              valid_reg;
  logic [INST_W-1:0] inst_reg;
  logic [31:0]       pc_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_reg <= 1'b0;
      inst_reg  <= '0;
      pc_reg    <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      inst_reg  <= in_inst;
      pc_reg    <= in_pc;
    end else if (valid_reg && out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_valid = valid_reg;
  assign out_inst  = inst_reg;
  assign out_pc    = pc_reg;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch controller for an asynchronous instruction ROM: owns the PC, sequences
// IDLE/RUN/PAUSE/HALT, applies redirects and counts accepted instructions.
module inst_fetch_ctrl
  import cpu_defs::*;
#(
  parameter int          ADDR_W   = 5,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              run_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [31:0]       out_pc,
  output logic [31:0]       fetch_pc,
  output logic              fetch_err,
  output logic [CNT_W-1:0]  fetch_cnt
);

  fetch_state_t     state_reg, state_next;
  logic [31:0]      pc_reg, pc_next;
  logic             err_reg, err_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             load, flush;
  logic             handshake;

  assign handshake = out_valid && out_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
      pc_reg    <= RESET_PC;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      err_reg   <= err_next;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_reg <= '0;
    end else if (handshake && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    err_next   = err_reg;
    load       = 1'b0;
    flush      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        state_next = run_en ? ST_RUN : ST_PAUSE;
      end
      ST_RUN, ST_PAUSE: begin
        if (redirect_valid) begin
          // The target is fetched next cycle; the staged instruction is stale.
          flush = 1'b1;
          if (redirect_target[1:0] != 2'b00) begin
            err_next   = 1'b1;
            state_next = ST_HALT;
          end else begin
            pc_next    = redirect_target;
            state_next = run_en ? ST_RUN : ST_PAUSE;
          end
        end else begin
          if (state_reg == ST_RUN) begin
            load = !out_valid || out_ready;
            if (load) pc_next = pc_reg + 32'd4;
          end
          state_next = run_en ? ST_RUN : ST_PAUSE;
        end
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_HALT;
      end
    endcase
  end

  fetch_out_stage u_out_stage (
    .clk       (clk),
    .resetn    (resetn),
    .load      (load),
    .flush     (flush),
    .in_inst   (rom_inst),
    .in_pc     (pc_reg),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_inst  (out_inst),
    .out_pc    (out_pc)
  );

  assign rom_addr  = pc_reg[ADDR_W+1:2];
  assign fetch_pc  = pc_reg;
  assign fetch_err = err_reg;
  assign fetch_cnt = cnt_reg;

endmodule
